// File: rtl/connect_flit_receiver.sv
// rtl/connect_flit_receiver.sv - CONNECT receive endpoint: per-VC flit buffers, packet-locked round-robin delivery, credit return
module connect_flit_receiver #(
   parameter int NUM_VCS    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int DEST_BITS  = 4,
   parameter int BUF_DEPTH  = 8,
   parameter int VC_BITS    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
   parameter int FLIT_W     = 2 + DATA_WIDTH + DEST_BITS + VC_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FLIT_W-1:0]     flit_in,
   output logic                  en_receiveFlit,
   output logic [VC_BITS:0]      credit_out,
   output logic                  sendCredit,
   input  logic [DEST_BITS-1:0]  recvPortID,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_tail,
   output logic [VC_BITS-1:0]    out_vc,
   output logic                  err_overflow,
   output logic                  err_dest,
   output logic [15:0]           flit_count
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 1 + DATA_WIDTH;

   // Flit fields, MSB..LSB: valid, tail, dest, vc, data
   logic                  in_valid;
   logic                  in_tail;
   logic [DEST_BITS-1:0]  in_dest;
   logic [VC_BITS-1:0]    in_vc;
   logic [DATA_WIDTH-1:0] in_data;

   assign in_valid = flit_in[FLIT_W-1];
   assign in_tail  = flit_in[FLIT_W-2];
   assign in_dest  = flit_in[FLIT_W-3 -: DEST_BITS];
   assign in_vc    = flit_in[DATA_WIDTH +: VC_BITS];
   assign in_data  = flit_in[DATA_WIDTH-1:0];

   // Per-VC circular buffers holding {tail, data}
   logic [ENT_W-1:0] mem_q    [NUM_VCS][BUF_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q [NUM_VCS];
   logic [PTR_W-1:0] wr_ptr_q [NUM_VCS];
   logic [CNT_W-1:0] cnt_q    [NUM_VCS];

   logic               en_q;
   logic               locked_q, locked_d;
   logic [VC_BITS-1:0] cur_vc_q, cur_vc_d;
   logic [VC_BITS-1:0] rr_ptr_q, rr_ptr_d;
   logic               send_q;
   logic [VC_BITS:0]   credit_q;
   logic               err_ovf_q, err_dest_q;
   logic [15:0]        flit_count_q;

   logic [VC_BITS-1:0] sel;
   logic [ENT_W-1:0]   head;
   logic               pop;
   logic               wr_req;
   logic [NUM_VCS-1:0] wr_en;
   logic               overflow;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (int'(p) == BUF_DEPTH - 1) return '0;
      return p + PTR_W'(1);
   endfunction

   // Pick the VC to present: the locked VC, else first non-empty VC from rr_ptr upward
   always_comb begin
      int idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      sel   = rr_ptr_q;
      if (locked_q) begin
         sel = cur_vc_q;
      end else begin
         for (int i = 0; i < NUM_VCS; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_VCS;
            if (!found && cnt_q[idx] != '0) begin
               sel   = VC_BITS'(idx);
               found = 1'b1;
            end
         end
      end
   end

   assign head      = mem_q[sel][rd_ptr_q[sel]];
   assign out_valid = (cnt_q[sel] != '0);
   assign out_data  = head[DATA_WIDTH-1:0];
   assign out_tail  = head[DATA_WIDTH];
   assign out_vc    = sel;
   assign pop       = out_valid && out_ready;

   // Write acceptance: room in the VC, or its head leaves this same cycle; unknown VCs are dropped
   always_comb begin
      wr_req = en_q && in_valid;
      wr_en  = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         if (wr_req && in_vc == VC_BITS'(v) &&
             (cnt_q[v] != CNT_W'(BUF_DEPTH) || (pop && sel == VC_BITS'(v)))) begin
            wr_en[v] = 1'b1;
         end
      end
      overflow = wr_req && (wr_en == '0);
   end

   // Lock and round-robin pointer next state on a pop
   always_comb begin
      locked_d = locked_q;
      cur_vc_d = cur_vc_q;
      rr_ptr_d = rr_ptr_q;
      if (pop) begin
         if (out_tail) begin
            locked_d = 1'b0;
            rr_ptr_d = (int'(sel) == NUM_VCS - 1) ? '0 : sel + VC_BITS'(1);
         end else begin
            locked_d = 1'b1;
            cur_vc_d = sel;
         end
      end
   end

   // Buffer storage needs no reset: occupancy counters define validity
   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VCS; v++) begin
         if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= {in_tail, in_data};
      end
   end

   // Control state: pointers, counts, lock, credits, error flags, delivered count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q         <= 1'b0;
         locked_q     <= 1'b0;
         cur_vc_q     <= '0;
         rr_ptr_q     <= '0;
         send_q       <= 1'b0;
         credit_q     <= '0;
         err_ovf_q    <= 1'b0;
         err_dest_q   <= 1'b0;
         flit_count_q <= '0;
         for (int v = 0; v < NUM_VCS; v++) begin
            rd_ptr_q[v] <= '0;
            wr_ptr_q[v] <= '0;
            cnt_q[v]    <= '0;
         end
      end else begin
         en_q     <= 1'b1;
         locked_q <= locked_d;
         cur_vc_q <= cur_vc_d;
         rr_ptr_q <= rr_ptr_d;
         send_q   <= pop;
         credit_q <= pop ? {1'b1, sel} : '0;
         if (pop) flit_count_q <= flit_count_q + 16'd1;
         if (overflow) err_ovf_q <= 1'b1;
         if (wr_req && in_dest != recvPortID) err_dest_q <= 1'b1;
         for (int v = 0; v < NUM_VCS; v++) begin
            logic pop_v;
            pop_v = pop && (sel == VC_BITS'(v));
            if (wr_en[v]) wr_ptr_q[v] <= ptr_inc(wr_ptr_q[v]);
            if (pop_v)    rd_ptr_q[v] <= ptr_inc(rd_ptr_q[v]);
            if (wr_en[v] && !pop_v)      cnt_q[v] <= cnt_q[v] + CNT_W'(1);
            else if (!wr_en[v] && pop_v) cnt_q[v] <= cnt_q[v] - CNT_W'(1);
         end
      end
   end

   assign en_receiveFlit = en_q;
   assign sendCredit     = send_q;
   assign credit_out     = credit_q;
   assign err_overflow   = err_ovf_q;
   assign err_dest       = err_dest_q;
   assign flit_count     = flit_count_q;

endmodule
